mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// CPU request/response and word-RAM signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the CPU and RAM side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a word-wide RAM with 1-cycle read.
// Sub-word stores are done as read-modify-write of the containing word.
module mem_access_unit (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  function automatic logic is_illegal(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = wr;
      3'b101:  bad = wr | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] a,
                                              input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Only B (000) and H (001) stores reach the merge.
  function automatic logic [31:0] merge_store(input logic [2:0] f3,
                                              input logic [1:0] a,
                                              input logic [31:0] w,
                                              input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00) r[{a, 3'b000} +: 8] = d[7:0];
    else if (a[1])        r[31:16] = d[15:0];
    else                  r[15:0]  = d[15:0];
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (is_illegal(bus.req_write, bus.req_funct3, bus.req_addr[1:0])) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.req_write && bus.req_funct3 == 3'b010) begin
            state_d = WR;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: state_d = RD_WAIT;
      // Response registers change only on entry to DONE so they hold between responses.
      RD_WAIT: begin
        if (write_q) begin
          wdata_d = merge_store(funct3_q, addr_q[1:0], bus.mem_rdata, wdata_q);
          state_d = WR;
        end else begin
          rdata_d = load_extend(funct3_q, addr_q[1:0], bus.mem_rdata);
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      WR: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request payload is only consumed outside IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    write_q  <= write_d;
    funct3_q <= funct3_d;
    wdata_q  <= wdata_d;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_read  = (state_q == RD_REQ);
  assign bus.mem_write = (state_q == WR);
  assign bus.mem_wdata = (state_q == WR) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word RAM model with 1-cycle registered read,
// response scoreboard with latency tracking, and strobe monitors.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  exp_t        sb[$];
  wr_t         wlog[$];
  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  int          bad_wd = 0;
  int          resp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data appears in the cycle after the read strobe, 0 otherwise.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_read ? mem[bus.mem_addr[7:2]] : 32'h0;
    if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (bus.mem_read) rd_cnt++;
    if (bus.mem_write) begin
      wr_cnt++;
      wlog.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
    end
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (!bus.mem_write && bus.mem_wdata !== 32'h0) bad_wd++;
    if (bus.rsp_valid === 1'b1) begin
      exp_t e;
      resp_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata: got %08h, required %08h", bus.rsp_rdata, e.rdata);
        end
        checks++;
        if (bus.rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_err: got %0b, required %0b", bus.rsp_err, e.err);
        end
        checks++;
        if (cyc - e.acc_cyc + 1 != e.lat) begin
          errors++;
          $display("FAIL latency: got %0d, required %0d", cyc - e.acc_cyc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input bit track);
    int n = 0;
    while (bus.req_ready !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        $display("FAIL req_ready_timeout: ready stuck low, required high within 20 cycles");
        $fatal(1, "bench stopped");
      end
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    if (track) sb.push_back('{rdata: exp_rd, err: exp_err, lat: lat, acc_cyc: cyc});
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 30) begin
        $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
        $fatal(1, "bench stopped");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; bad_wd = 0; resp_cnt = 0;
    wlog.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/err = %b%b%b, required 100",
               bus.req_ready, bus.rsp_valid, bus.rsp_err);
    end
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rd=%b wr=%b addr=%08h wdata=%08h rdata=%08h, required all 0",
               bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.rsp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    clear_mon();
    mem[4] = 32'h8899AABB;
    issue(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 1'b1);
    drain();
    issue(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, 3, 1'b1);
    drain();
    issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 3, 1'b1);
    drain();
    issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 3, 1'b1);
    drain();
    issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 3, 1'b1);
    drain();
    issue(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 3, 1'b1);
    drain();
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, 1'b1);
    drain();
    checks++;
    if (wr_cnt != 0 || rd_cnt != 7 || both_cnt != 0) begin
      errors++;
      $display("FAIL load_strobes: reads=%0d writes=%0d both=%0d, required 7/0/0",
               rd_cnt, wr_cnt, both_cnt);
    end
    checks++;
    if (bus.mem_addr !== 32'h10 || bus.rsp_rdata !== 32'h8899AABB) begin
      errors++;
      $display("FAIL load_hold: mem_addr=%08h rsp_rdata=%08h, required 00000010/8899aabb",
               bus.mem_addr, bus.rsp_rdata);
    end
  endtask

  task automatic test_store_sub();
    clear_mon();
    mem[8] = 32'h11223344;
    issue(1'b1, 3'b000, 32'h22, 32'h12345655, 32'h0, 1'b0, 4, 1'b1);
    drain();
    checks++;
    if (rd_cnt != 1 || wr_cnt != 1 || wlog.size() != 1) begin
      errors++;
      $display("FAIL sb_strobes: reads=%0d writes=%0d, required 1/1", rd_cnt, wr_cnt);
    end else begin
      checks++;
      if (wlog[0].a !== 32'h20 || wlog[0].d !== 32'h11553344) begin
        errors++;
        $display("FAIL sb_write: addr=%08h data=%08h, required 00000020/11553344",
                 wlog[0].a, wlog[0].d);
      end
    end
    clear_mon();
    issue(1'b1, 3'b001, 32'h22, 32'h0000CAFE, 32'h0, 1'b0, 4, 1'b1);
    drain();
    checks++;
    if (wlog.size() != 1 || mem[8] !== 32'hCAFE3344) begin
      errors++;
      $display("FAIL sh_write: writes=%0d mem=%08h, required 1/cafe3344", wlog.size(), mem[8]);
    end
  endtask

  task automatic test_store_word();
    clear_mon();
    issue(1'b1, 3'b010, 32'h30, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    drain();
    checks++;
    if (rd_cnt != 0 || wr_cnt != 1 || wlog.size() != 1) begin
      errors++;
      $display("FAIL sw_strobes: reads=%0d writes=%0d, required 0/1", rd_cnt, wr_cnt);
    end else begin
      checks++;
      if (wlog[0].a !== 32'h30 || wlog[0].d !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL sw_write: addr=%08h data=%08h, required 00000030/deadbeef",
                 wlog[0].a, wlog[0].d);
      end
    end
  endtask

  task automatic test_errors();
    clear_mon();
    issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    issue(1'b1, 3'b001, 32'h43, 32'hFFFF, 32'h0, 1'b1, 1, 1'b1);
    drain();
    issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    issue(1'b1, 3'b100, 32'h40, 32'h7, 32'h0, 1'b1, 1, 1'b1);
    drain();
    issue(1'b0, 3'b101, 32'h41, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    checks++;
    if (rd_cnt != 0 || wr_cnt != 0 || resp_cnt != 5) begin
      errors++;
      $display("FAIL err_strobes: reads=%0d writes=%0d rsps=%0d, required 0/0/5",
               rd_cnt, wr_cnt, resp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    mem[4] = 32'h8899AABB;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, 1'b1);
    issue(1'b1, 3'b010, 32'h34, 32'h01020304, 32'h0, 1'b0, 2, 1'b1);
    checks++;
    if (bus.rsp_rdata !== 32'h8899AABB || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdata_hold: rdata=%08h valid=%b, required 8899aabb/0",
               bus.rsp_rdata, bus.rsp_valid);
    end
    issue(1'b0, 3'b000, 32'h34, 32'h0, 32'h00000004, 1'b0, 3, 1'b1);
    drain();
    checks++;
    if (mem[13] !== 32'h01020304 || both_cnt != 0 || bad_wd != 0) begin
      errors++;
      $display("FAIL b2b_mem: mem=%08h both=%0d stray_wdata=%0d, required 01020304/0/0",
               mem[13], both_cnt, bad_wd);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    mem[8] = 32'h11223344;
    issue(1'b1, 3'b000, 32'h21, 32'hAA, 32'h0, 1'b0, 4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != 0 || resp_cnt != 0 || rd_cnt != 1 || mem[8] !== 32'h11223344) begin
      errors++;
      $display("FAIL reset_abort: writes=%0d rsps=%0d reads=%0d mem=%08h, required 0/0/1/11223344",
               wr_cnt, resp_cnt, rd_cnt, mem[8]);
    end
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort_state: ready=%b mem_addr=%08h, required 1/00000000",
               bus.req_ready, bus.mem_addr);
    end
    issue(1'b1, 3'b000, 32'h21, 32'hAA, 32'h0, 1'b0, 4, 1'b1);
    drain();
    checks++;
    if (mem[8] !== 32'h1122AA44 || wr_cnt != 1) begin
      errors++;
      $display("FAIL after_reset: mem=%08h writes=%0d, required 1122aa44/1", mem[8], wr_cnt);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_store_sub();
    test_store_word();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
